// File: rtl/stepper_pkg.sv
// stepper_pkg: register map, status bit positions and step filter state shared by the stepper blocks.
package stepper_pkg;
    localparam logic [1:0] ADDR_POS    = 2'd0;
    localparam logic [1:0] ADDR_LOWER  = 2'd1;
    localparam logic [1:0] ADDR_UPPER  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;
    localparam int ST_ENABLE    = 0;
    localparam int ST_FAULT     = 1;
    localparam int ST_COLLISION = 2;
    localparam int ST_DIR       = 3;
    typedef enum logic {FILT_IDLE, FILT_ARMED} filt_state_e;
endpackage

// File: rtl/step_edge_filter.sv
// step_edge_filter: synchronizes step/dir and emits one count event per step pulse
// that stays high for at least MIN_HIGH synchronized cycles.
module step_edge_filter
    import stepper_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_i,
    input  logic dir_i,
    output logic count_evt_o,
    output logic dir_s_o
);
    localparam int CW = $clog2(MIN_HIGH + 1);
    localparam int WW = $clog2(SYNC_STAGES + 1);
    logic [SYNC_STAGES-1:0] step_sync_q, dir_sync_q;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [WW-1:0] warm_q;
    filt_state_e state_q, state_d;
    logic step_s, warm;
    assign step_s  = step_sync_q[SYNC_STAGES-1];
    assign dir_s_o = dir_sync_q[SYNC_STAGES-1];
    assign warm    = warm_q == WW'(SYNC_STAGES);
    // Leaving reset ARMED, and only disarming once the synchronizer holds real
    // pin samples, keeps a pulse that straddles reset from being counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_sync_q <= '0;
            dir_sync_q  <= '0;
            hi_cnt_q    <= '0;
            warm_q      <= '0;
            state_q     <= FILT_ARMED;
        end else begin
            step_sync_q <= (step_sync_q << 1) | SYNC_STAGES'(step_i);
            dir_sync_q  <= (dir_sync_q << 1) | SYNC_STAGES'(dir_i);
            hi_cnt_q    <= hi_cnt_d;
            state_q     <= state_d;
            if (!warm) warm_q <= warm_q + WW'(1);
        end
    end
    always_comb begin
        state_d     = state_q;
        hi_cnt_d    = hi_cnt_q;
        count_evt_o = 1'b0;
        if (state_q == FILT_IDLE) begin
            if (!step_s) begin
                hi_cnt_d = '0;
            end else if (hi_cnt_q == CW'(MIN_HIGH - 1)) begin
                count_evt_o = 1'b1;
                hi_cnt_d    = '0;
                state_d     = FILT_ARMED;
            end else begin
                hi_cnt_d = hi_cnt_q + CW'(1);
            end
        end else if (warm && !step_s) begin
            state_d = FILT_IDLE;
        end
    end
endmodule

// File: rtl/step_monitor.sv
// step_monitor: tracks signed absolute position from step/dir, checks soft limits
// with a sticky fault, and exposes everything on the stepper register bus.
module step_monitor
    import stepper_pkg::*;
#(
    parameter int POS_WIDTH   = 32,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        step,
    input  logic        dir,
    output logic        fault
);
    logic signed [POS_WIDTH-1:0] pos_q, pos_d, lower_q, lower_d, upper_q, upper_d;
    logic enable_q, enable_d, fault_q, fault_d, coll_q, coll_d;
    logic [31:0] rd_q, rd_d, status;
    logic count_evt, dir_s, evt, wr_pos, wr_st, out_of_range;
    step_edge_filter #(.SYNC_STAGES(SYNC_STAGES), .MIN_HIGH(MIN_HIGH)) u_filter (
        .clk        (clk),
        .rst_n      (reset),
        .step_i     (step),
        .dir_i      (dir),
        .count_evt_o(count_evt),
        .dir_s_o    (dir_s)
    );
    assign evt          = count_evt && enable_q;
    assign wr_pos       = write && address == ADDR_POS;
    assign wr_st        = write && address == ADDR_STATUS;
    assign out_of_range = pos_q > upper_q || pos_q < lower_q;
    assign status       = 32'({dir_s, coll_q, fault_q, enable_q});
    assign readdata     = rd_q;
    assign fault        = fault_q && enable_q;
    always_comb begin
        pos_d    = wr_pos ? POS_WIDTH'(writedata) : evt ? pos_q + (dir_s ? POS_WIDTH'(1) : '1) : pos_q;
        lower_d  = (write && address == ADDR_LOWER) ? POS_WIDTH'(writedata) : lower_q;
        upper_d  = (write && address == ADDR_UPPER) ? POS_WIDTH'(writedata) : upper_q;
        enable_d = wr_st ? writedata[ST_ENABLE] : enable_q;
        fault_d  = out_of_range || (fault_q && !(wr_st && writedata[ST_FAULT]));
        coll_d   = (wr_pos && evt) || (coll_q && !(wr_st && writedata[ST_COLLISION]));
        rd_d     = !read ? rd_q :
                   address == ADDR_POS   ? 32'(pos_q) :
                   address == ADDR_LOWER ? 32'(lower_q) :
                   address == ADDR_UPPER ? 32'(upper_q) : status;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q    <= '0;
            lower_q  <= {1'b1, {(POS_WIDTH-1){1'b0}}};
            upper_q  <= {1'b0, {(POS_WIDTH-1){1'b1}}};
            enable_q <= 1'b1;
            fault_q  <= 1'b0;
            coll_q   <= 1'b0;
            rd_q     <= '0;
        end else begin
            pos_q    <= pos_d;
            lower_q  <= lower_d;
            upper_q  <= upper_d;
            enable_q <= enable_d;
            fault_q  <= fault_d;
            coll_q   <= coll_d;
            rd_q     <= rd_d;
        end
    end
endmodule

// File: tb/tb_step_monitor.sv
// tb_step_monitor: randomized step/dir and register traffic against a pulse-level position model.
module tb_step_monitor;
    localparam int SYNC = 2;
    localparam int MH   = 2;
    logic clk = 1'b0, reset = 1'b1, write = 1'b0, read = 1'b0, step = 1'b0, dir = 1'b0;
    logic [1:0] address = 2'd0;
    logic [31:0] writedata = '0, readdata;
    logic fault;
    int vectors = 0, miscompares = 0;
    logic signed [31:0] m_pos, m_lo, m_hi;
    logic m_en, m_flt, m_col, m_dir;

    always #5 clk = ~clk;

    step_monitor #(.POS_WIDTH(32), .SYNC_STAGES(SYNC), .MIN_HIGH(MH)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
        .read(read), .readdata(readdata), .step(step), .dir(dir), .fault(fault)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_pos = 0; m_lo = 32'h8000_0000; m_hi = 32'h7FFF_FFFF;
        m_en = 1'b1; m_flt = 1'b0; m_col = 1'b0; m_dir = 1'b0;
    endfunction

    function automatic void model_limit();
        if (m_pos > m_hi || m_pos < m_lo) m_flt = 1'b1;
    endfunction

    task automatic wr(logic [1:0] a, logic [31:0] d);
        tick(SYNC + MH + 1);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
        case (a)
            2'd0: m_pos = d;
            2'd1: m_lo = d;
            2'd2: m_hi = d;
            default: begin
                m_en = d[0];
                if (d[1]) m_flt = 1'b0;
                if (d[2]) m_col = 1'b0;
            end
        endcase
        model_limit();
    endtask

    task automatic rd_chk(string tag, logic [1:0] a, logic [31:0] exp);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
        check(tag, readdata, exp);
    endtask

    task automatic check_all(string tag);
        tick(SYNC + MH + 2);
        rd_chk({tag, ".pos"}, 2'd0, m_pos);
        rd_chk({tag, ".status"}, 2'd3, {28'd0, m_dir, m_col, m_flt, m_en});
        check({tag, ".fault"}, {31'd0, fault}, {31'd0, m_flt & m_en});
    endtask

    task automatic pulse(logic d, int hi, int lo);
        dir = d; step = 1'b1;
        tick(hi);
        step = 1'b0;
        tick(lo);
        if (hi >= MH && m_en) m_pos = m_pos + (d ? 32'sd1 : -32'sd1);
        m_dir = d;
        model_limit();
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b0;
        tick(2);
        check("in_reset.readdata", readdata, 32'd0);
        check("in_reset.fault", {31'd0, fault}, 32'd0);
        reset = 1'b1;
        check_all("reset");

        for (int i = 0; i < 10; i++) pulse(1'b1, 2, 2);
        check_all("up10");
        for (int i = 0; i < 10; i++) pulse(1'b0, 2, 2);
        check_all("down10");

        wr(2'd2, 32'd5);
        for (int i = 0; i < 6; i++) pulse(1'b1, 2, 2);
        check_all("over_upper");
        for (int i = 0; i < 2; i++) pulse(1'b0, 2, 2);
        check_all("sticky");
        wr(2'd3, 32'h2);
        check_all("clear");
        wr(2'd3, 32'h1);
        check_all("reenable");

        wr(2'd2, 32'h7FFF_FFFF);
        wr(2'd0, 32'h7FFF_FFFF);
        pulse(1'b1, 2, 2);
        check_all("wrap");
        wr(2'd3, 32'h0);
        pulse(1'b1, 2, 2);
        check_all("disabled");
        wr(2'd3, 32'h1);

        pulse(1'b1, 1, 3);
        check_all("glitch");
        pulse(1'b1, 40, 3);
        check_all("long");

        // Position write lands on the same edge as the count event.
        tick(SYNC + MH + 1);
        dir = 1'b1; step = 1'b1;
        tick(SYNC + MH - 1);
        address = 2'd0; writedata = 32'd100; write = 1'b1;
        tick();
        write = 1'b0;
        tick(2);
        step = 1'b0;
        tick(3);
        m_pos = 100; m_col = 1'b1; m_dir = 1'b1;
        model_limit();
        check_all("collision");
        wr(2'd3, 32'h5);
        check_all("coll_clear");

        address = 2'd1; writedata = 32'd123; write = 1'b1; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        check("rw_same.old", readdata, m_lo);
        m_lo = 123;
        model_limit();
        rd_chk("rw_same.new", 2'd1, 32'd123);

        wr(2'd1, -32'sd20);
        wr(2'd0, 32'd0);
        wr(2'd2, 32'd20);
        wr(2'd3, 32'h3);
        rd_chk("lim.lower", 2'd1, -32'sd20);
        rd_chk("lim.upper", 2'd2, 32'd20);
        for (int i = 0; i < 80; i++) begin
            pulse(1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) wr(2'd3, {29'd0, 3'($urandom_range(0, 7)) | 3'b001});
            if (i % 10 == 9) check_all("random");
        end

        wr(2'd0, 32'd77);
        rd_chk("pre_reset.pos", 2'd0, 32'd77);
        dir = 1'b1; step = 1'b1;
        tick(2);
        #2 reset = 1'b0;
        #1;
        check("async_reset.readdata", readdata, 32'd0);
        check("async_reset.fault", {31'd0, fault}, 32'd0);
        tick();
        reset = 1'b1;
        model_reset();
        m_dir = 1'b1;
        tick(10);
        check_all("inflight");
        step = 1'b0;
        tick(3);
        pulse(1'b1, 3, 3);
        check_all("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
